l1_dcache_ctrl: RTL and testbench
=================================

Name: l1_dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits directly downstream of the processor's load/store path and replaces the flat data memory.
- Serves hits in the same cycle. On a miss it stalls the core, evicts the victim line if dirty, and refills it from the shared memory bus through a req/ack handshake.
- One instance per core in the multicore build.

Parameters:
- NUM_LINES, 64, number of cache lines (power of 2)
- LINE_WORDS, 4, 32-bit words per line (power of 2)
- ADDR_W, 32, byte-address width
- Derived: OFF_W = log2(LINE_WORDS) + 2; IDX_W = log2(NUM_LINES); TAG_W = ADDR_W - IDX_W - OFF_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- addr  in  ADDR_W  byte address from ALU
- wdata  in  32  store data (rs2)
- mask  in  3  access size/sign, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd_en  in  1  load request
- wr_en  in  1  store request
- rdata  out  32  load data, sign/zero extended per mask
- stall  out  1  freeze PC/regfile writes while high
- misalign  out  1  access not naturally aligned
- mem_req  out  1  bus request
- mem_we  out  1  1 = line writeback, 0 = line fetch
- mem_addr  out  ADDR_W  line-aligned address (low OFF_W bits zero)
- mem_wdata  out  32*LINE_WORDS  victim line data
- mem_rdata  in  32*LINE_WORDS  refill line data
- mem_ack  in  1  single-cycle completion pulse

Behaviour:
- Address split: tag = addr[ADDR_W-1:IDX_W+OFF_W], index = addr[IDX_W+OFF_W-1:OFF_W], word = addr[OFF_W-1:2].
- Reset (synchronous, one cycle):
  - All valid and dirty bits are cleared.
  - FSM goes to IDLE.
  - stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, misalign=0.
  - Reset asserted mid-miss abandons the transaction; mem_req is 0 the cycle after reset is sampled, and the target line is not written.
- FSM states: IDLE, WRITEBACK, ALLOCATE, RESOLVE.
- IDLE, no request: stall=0.
- IDLE, request hit (valid and tag match):
  - stall=0 combinationally.
  - Load: rdata is combinational in the same cycle.
  - Store: merges bytes per mask at the clock edge and sets dirty.
- Byte/half lanes on stores: selected by addr[1:0] for B and addr[1] for H.
- Load extension: B/H are sign-extended; BU/HU are zero-extended.
- IDLE, miss: stall=1 combinationally in the same cycle.
  - Next state is WRITEBACK if the victim is valid and dirty, otherwise ALLOCATE.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr = {victim_tag, index, 0}, mem_wdata = victim line.
  - On mem_ack: go to ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, 0}.
  - On mem_ack: write mem_rdata into the line, set tag, valid=1, dirty=0, go to RESOLVE.
- RESOLVE: stall=1 for one cycle, then return to IDLE, where the access now hits and completes.
- Miss latency: clean miss = 3 + bus wait cycles; dirty miss adds one more bus transaction.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable while mem_req=1 and until mem_ack is sampled.
  - mem_req drops the cycle after ack.
  - mem_ack outside WRITEBACK/ALLOCATE is ignored.
- Request ordering:
  - The processor holds addr/wdata/mask/rd_en/wr_en stable while stall=1.
  - rd_en and wr_en both high is treated as a store.
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0, raises misalign=1 combinationally.
  - No cache state change, no miss, stall=0, rdata=0.
- Unused mask codes (011, 110, 111) are treated as W.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both cleared by reset.
  - hit_cnt increments once per completed access that hit in IDLE without a preceding miss.
  - miss_cnt increments once per miss on the IDLE to WRITEBACK/ALLOCATE transition; the RESOLVE replay is not counted as a hit.
  - Both counters saturate at 0xFFFFFFFF.
- When undefined: the ports and counters do not exist, and core behaviour is identical.

Test Plan:
- Cold load:
  - Stimulus: after reset, rd_en, addr=0x0000_0100, mask=010; ack after 2 cycles with line word0=0xDEADBEEF.
  - Required: stall for 5 cycles; ALLOCATE with mem_addr=0x100; rdata=0xDEADBEEF in IDLE.
- Store hit then signed byte load:
  - Stimulus: sw 0x1234_5680 @0x104 (hit, stall=0), then lb @0x104.
  - Required: rdata=0xFFFF_FF80; lbu @0x104 gives 0x0000_0080.
- Dirty eviction:
  - Stimulus: dirty line at index of 0x100; load 0x0000_0500 with NUM_LINES=64, LINE_WORDS=4.
  - Required: WRITEBACK with mem_we=1, mem_addr=0x100, carrying the stored data; then ALLOCATE with mem_addr=0x500.
- Misalign:
  - Stimulus: lw @0x102.
  - Required: misalign=1, stall=0, no mem_req, rdata=0.
- Reset mid-refill:
  - Stimulus: assert reset while in ALLOCATE before ack.
  - Required: mem_req=0 next cycle; a subsequent load of the same address misses again.
- DCACHE_STATS_EN:
  - Stimulus: after the sequence cold load, 3 hits, 1 miss.
  - Required: hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Optional hit/miss counters are enabled with the DCACHE_STATS_EN macro.
module l1_dcache_ctrl #(
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [31:0]              i_wdata,
  input  logic [2:0]               i_mask,
  input  logic                     i_rd_en,
  input  logic                     i_wr_en,
  output logic [31:0]              o_rdata,
  output logic                     o_stall,
  output logic                     o_misalign,
`ifdef DCACHE_STATS_EN
  output logic [31:0]              o_hit_cnt,
  output logic [31:0]              o_miss_cnt,
`endif
  output logic                     o_mem_req,
  output logic                     o_mem_we,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [32*LINE_WORDS-1:0] o_mem_wdata,
  input  logic [32*LINE_WORDS-1:0] i_mem_rdata,
  input  logic                     i_mem_ack
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINE_W = 32 * LINE_WORDS;
  localparam int unsigned WORD_W = OFF_W - 2;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StResolve} state_t;

  state_t              r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_LINES];
  logic [LINE_W-1:0]   r_data [NUM_LINES];
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_mem_wdata;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_word;
  logic              w_is_b, w_is_h, w_req, w_misalign, w_hit, w_access, w_miss;
  logic [LINE_W-1:0] w_line, w_merged;
  logic [31:0]       w_rword, w_wword;
  logic [7:0]        w_rbyte;
  logic [15:0]       w_rhalf;
  logic [3:0]        w_be;

  assign w_tag  = i_addr[ADDR_W-1 -: TAG_W];
  assign w_idx  = i_addr[OFF_W +: IDX_W];
  assign w_word = i_addr[2 +: WORD_W];
  // Unused codes 011/110/111 fall through to word size.
  assign w_is_b = (i_mask[1:0] == 2'b00);
  assign w_is_h = (i_mask[1:0] == 2'b01);
  assign w_req  = i_rd_en | i_wr_en;

  assign w_misalign = (r_state == StIdle) && w_req &&
                      ((w_is_h && i_addr[0]) ||
                       (!w_is_b && !w_is_h && (i_addr[1:0] != 2'b00)));
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_access = (r_state == StIdle) && w_req && !w_misalign;
  assign w_miss   = w_access && !w_hit;

  assign w_line  = r_data[w_idx];
  assign w_rword = w_line[32*int'(w_word) +: 32];
  assign w_rbyte = w_rword[8*int'(i_addr[1:0]) +: 8];
  assign w_rhalf = w_rword[16*int'(i_addr[1]) +: 16];

  assign o_stall     = (r_state != StIdle) || w_miss;
  assign o_misalign  = w_misalign;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  always_comb begin
    o_rdata = '0;
    if (w_access && w_hit && !i_wr_en) begin
      if (w_is_b)      o_rdata = i_mask[2] ? {24'b0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
      else if (w_is_h) o_rdata = i_mask[2] ? {16'b0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
      else             o_rdata = w_rword;
    end
  end

  always_comb begin
    if (w_is_b) begin
      w_be    = 4'b0001 << i_addr[1:0];
      w_wword = {4{i_wdata[7:0]}};
    end else if (w_is_h) begin
      w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
      w_wword = {2{i_wdata[15:0]}};
    end else begin
      w_be    = 4'b1111;
      w_wword = i_wdata;
    end
    w_merged = w_line;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) w_merged[32*int'(w_word) + 8*b +: 8] = w_wword[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_access && w_hit && i_wr_en) begin
            r_data[w_idx]  <= w_merged;
            r_dirty[w_idx] <= 1'b1;
          end else if (w_miss && r_valid[w_idx] && r_dirty[w_idx]) begin
            r_state     <= StWriteback;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
            r_mem_wdata <= w_line;
          end else if (w_miss) begin
            r_state    <= StAllocate;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
          end
        end
        StWriteback: begin
          if (i_mem_ack) begin
            r_state    <= StAllocate;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
          end
        end
        StAllocate: begin
          if (i_mem_ack) begin
            r_state        <= StResolve;
            r_mem_req      <= 1'b0;
            r_data[w_idx]  <= i_mem_rdata;
            r_tag[w_idx]   <= w_tag;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        StResolve: r_state <= StIdle;
        default:   r_state <= StIdle;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_replay;
  logic [31:0] r_hit_cnt, r_miss_cnt;

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;

  // The first IDLE cycle after RESOLVE completes a missed access, not a new hit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_replay   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_replay <= (r_state == StResolve);
      if (w_access && w_hit && !r_replay && (r_hit_cnt != 32'hFFFF_FFFF))
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF))
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed self-checking bench for l1_dcache_ctrl (64 lines x 4 words, 32-bit addresses).
module tb_l1_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr, wdata, rdata;
  logic [2:0]   mask;
  logic         rd_en, wr_en, stall, misalign;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] Line1 = {32'h5555_6666, 32'h3333_4444, 32'h1111_2222, 32'hDEAD_BEEF};
  localparam logic [127:0] Line2 = {32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 32'hCAFE_F00D};

  always #5 clk = ~clk;

  l1_dcache_ctrl dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_mask      (mask),
    .i_rd_en     (rd_en),
    .i_wr_en     (wr_en),
    .o_rdata     (rdata),
    .o_stall     (stall),
    .o_misalign  (misalign),
`ifdef DCACHE_STATS_EN
    .o_hit_cnt   (hit_cnt),
    .o_miss_cnt  (miss_cnt),
`endif
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack)
  );

  task automatic set_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [2:0] m, input logic [31:0] wd);
    rd_en = rd;
    wr_en = wr;
    addr  = a;
    mask  = m;
    wdata = wd;
    #1;
  endtask

  // Bus responder: acks each transaction after wait_n cycles of mem_req, until stall drops.
  task automatic serve(input int wait_n, input logic [127:0] line, output int stalls,
                       output logic saw_wb, output logic [31:0] wb_addr,
                       output logic [127:0] wb_data, output logic [31:0] al_addr,
                       output logic done);
    int cnt = 0;
    stalls = 0; saw_wb = 0; wb_addr = 0; wb_data = 0; al_addr = 0; done = 0;
    for (int i = 0; i < 100; i++) begin
      if (!stall) begin
        done = 1;
        break;
      end
      stalls++;
      if (mem_req) begin
        if (cnt == wait_n) begin
          if (mem_we) begin
            saw_wb  = 1;
            wb_addr = mem_addr;
            wb_data = mem_wdata;
          end else begin
            al_addr   = mem_addr;
            mem_rdata = line;
          end
          mem_ack = 1;
          cnt     = 0;
        end else begin
          cnt++;
        end
      end
      @(negedge clk);
      #1;
      mem_ack = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    set_req(0, 0, 32'h0, 3'b010, 32'h0);
    mem_ack = 0;
    mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 128'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %0b want 0", misalign); end
  endtask

  task automatic test_cold_load();
    int st; logic wb, dn; logic [31:0] wa, aa; logic [127:0] wd;
    @(negedge clk);
    set_req(1, 0, 32'h100, 3'b010, 32'h0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL cold_stall_same_cycle got %0b want 1", stall); end
    serve(2, Line1, st, wb, wa, wd, aa, dn);
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL cold_timeout got %0b want 1", dn); end
    n_checks++; if (st != 5) begin n_fail++; $display("FAIL cold_stall_cycles got %0d want 5", st); end
    n_checks++; if (wb !== 1'b0) begin n_fail++; $display("FAIL cold_no_wb got %0b want 0", wb); end
    n_checks++; if (aa !== 32'h100) begin n_fail++; $display("FAIL cold_alloc_addr got %h want 100", aa); end
    n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cold_rdata got %h want deadbeef", rdata); end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    set_req(0, 1, 32'h104, 3'b010, 32'h1234_5680);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sw_hit_stall got %0b want 0", stall); end
    @(negedge clk);
    set_req(1, 0, 32'h104, 3'b000, 32'h0);
    n_checks++; if (rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb got %h want ffffff80", rdata); end
    set_req(1, 0, 32'h104, 3'b100, 32'h0);
    n_checks++; if (rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu got %h want 00000080", rdata); end
    set_req(1, 0, 32'h106, 3'b001, 32'h0);
    n_checks++; if (rdata !== 32'h0000_1234) begin n_fail++; $display("FAIL lh_pos got %h want 00001234", rdata); end
    // rd_en and wr_en together act as a store
    set_req(1, 1, 32'h107, 3'b000, 32'h0000_00AB);
    @(negedge clk);
    set_req(1, 0, 32'h106, 3'b001, 32'h0);
    n_checks++; if (rdata !== 32'hFFFF_AB34) begin n_fail++; $display("FAIL lh_neg got %h want ffffab34", rdata); end
    set_req(1, 0, 32'h106, 3'b101, 32'h0);
    n_checks++; if (rdata !== 32'h0000_AB34) begin n_fail++; $display("FAIL lhu got %h want 0000ab34", rdata); end
    set_req(1, 0, 32'h104, 3'b010, 32'h0);
    n_checks++; if (rdata !== 32'hAB34_5680) begin n_fail++; $display("FAIL lw_merged got %h want ab345680", rdata); end
  endtask

  task automatic test_dirty_evict();
    int st; logic wb, dn; logic [31:0] wa, aa; logic [127:0] wd;
    @(negedge clk);
    set_req(1, 0, 32'h500, 3'b010, 32'h0);
    serve(1, Line2, st, wb, wa, wd, aa, dn);
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL evict_timeout got %0b want 1", dn); end
    n_checks++; if (st != 6) begin n_fail++; $display("FAIL evict_stall_cycles got %0d want 6", st); end
    n_checks++; if (wb !== 1'b1) begin n_fail++; $display("FAIL evict_saw_wb got %0b want 1", wb); end
    n_checks++; if (wa !== 32'h100) begin n_fail++; $display("FAIL evict_wb_addr got %h want 100", wa); end
    n_checks++;
    if (wd !== {32'h5555_6666, 32'h3333_4444, 32'hAB34_5680, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL evict_wb_data got %h want 5555666633334444ab345680deadbeef", wd);
    end
    n_checks++; if (aa !== 32'h500) begin n_fail++; $display("FAIL evict_alloc_addr got %h want 500", aa); end
    n_checks++; if (rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL evict_rdata got %h want cafef00d", rdata); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL evict_req_dropped got %0b want 0", mem_req); end
    // Refilled line is clean, so evicting it needs no writeback.
    @(negedge clk);
    set_req(1, 0, 32'h100, 3'b010, 32'h0);
    serve(0, Line1, st, wb, wa, wd, aa, dn);
    n_checks++; if (st != 3 || wb !== 1'b0) begin n_fail++; $display("FAIL clean_evict got stalls %0d wb %0b want 3 0", st, wb); end
    n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL clean_evict_rdata got %h want deadbeef", rdata); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    set_req(1, 0, 32'h102, 3'b010, 32'h0);
    n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_lw got %0b want 1", misalign); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall got %0b want 0", stall); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata got %h want 0", rdata); end
    @(negedge clk);
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_mem_req got %0b want 0", mem_req); end
    set_req(1, 0, 32'h105, 3'b001, 32'h0);
    n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_lh got %0b want 1", misalign); end
    set_req(1, 0, 32'h106, 3'b001, 32'h0);
    n_checks++; if (misalign !== 1'b0 || rdata !== 32'h0000_1111) begin
      n_fail++; $display("FAIL aligned_lh got mis %0b data %h want 0 00001111", misalign, rdata);
    end
    // Misaligned store must not alter the line.
    set_req(0, 1, 32'h101, 3'b001, 32'hFFFF_FFFF);
    @(negedge clk);
    set_req(1, 0, 32'h100, 3'b010, 32'h0);
    n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mis_store_no_write got %h want deadbeef", rdata); end
  endtask

  task automatic test_reset_mid_refill();
    int st; logic wb, dn, seen; logic [31:0] wa, aa; logic [127:0] wd;
    seen = 0;
    @(negedge clk);
    set_req(1, 0, 32'h200, 3'b010, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (mem_req) begin seen = 1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_mid_alloc_seen got %0b want 1", seen); end
    reset = 1;
    set_req(0, 0, 32'h0, 3'b010, 32'h0);
    @(negedge clk);
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_req got %0b want 0", mem_req); end
    reset = 0;
    @(negedge clk);
    set_req(1, 0, 32'h200, 3'b010, 32'h0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_remiss got %0b want 1", stall); end
    serve(0, Line2, st, wb, wa, wd, aa, dn);
    n_checks++; if (dn !== 1'b1 || aa !== 32'h200) begin n_fail++; $display("FAIL rst_mid_refill got addr %h want 200", aa); end
    n_checks++; if (rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rst_mid_rdata got %h want cafef00d", rdata); end
    @(negedge clk);
    set_req(1, 0, 32'h100, 3'b010, 32'h0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_invalidates got %0b want 1", stall); end
    serve(0, Line1, st, wb, wa, wd, aa, dn);
    n_checks++; if (wb !== 1'b0) begin n_fail++; $display("FAIL rst_clears_dirty got %0b want 0", wb); end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    int st; logic wb, dn; logic [31:0] wa, aa; logic [127:0] wd;
    reset = 1;
    set_req(0, 0, 32'h0, 3'b010, 32'h0);
    @(negedge clk);
    reset = 0;
    #1;
    n_checks++; if (hit_cnt !== 0 || miss_cnt !== 0) begin n_fail++; $display("FAIL stats_reset got %0d %0d want 0 0", hit_cnt, miss_cnt); end
    set_req(1, 0, 32'h100, 3'b010, 32'h0);
    serve(0, Line1, st, wb, wa, wd, aa, dn);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_req(1, 0, 32'h100 + 32'(4 * i), 3'b010, 32'h0);
    end
    @(negedge clk);
    set_req(1, 0, 32'h300, 3'b010, 32'h0);
    serve(0, Line2, st, wb, wa, wd, aa, dn);
    @(negedge clk);
    set_req(0, 0, 32'h0, 3'b010, 32'h0);
    n_checks++; if (hit_cnt !== 32'd3) begin n_fail++; $display("FAIL stats_hits got %0d want 3", hit_cnt); end
    n_checks++; if (miss_cnt !== 32'd2) begin n_fail++; $display("FAIL stats_misses got %0d want 2", miss_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_load();
    test_store_load();
    test_dirty_evict();
    test_misalign();
    test_reset_mid_refill();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
